// File: rtl/cpu_run_ctrl.sv
// Run controller for MIPS cores: stretches reset, counts cycles/instructions, stops on halt or budget.
// Optional `RUN_CTRL_SIG_EN adds a 32-bit rotate-xor PC signature output.
module cpu_run_ctrl #(
    parameter int unsigned PC_WIDTH     = 32,
    parameter int unsigned CNT_WIDTH    = 32,
    parameter int unsigned RESET_CYCLES = 4,
    parameter int unsigned MAX_CYCLES   = 10000,
    parameter int unsigned HALT_REPEAT  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [PC_WIDTH-1:0]  pc,
    input  logic                 pc_valid,
    output logic                 cpu_reset,
    output logic [1:0]           state,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] instr_count,
    output logic                 halted,
    output logic                 timeout,
    output logic                 done
`ifdef RUN_CTRL_SIG_EN
    ,
    output logic [31:0]          signature
`endif
);

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_HOLD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int unsigned HOLD_W = $clog2(RESET_CYCLES + 1);
    localparam int unsigned REP_W  = $clog2(HALT_REPEAT);

    localparam logic [HOLD_W-1:0]    HOLD_LAST  = HOLD_W'(RESET_CYCLES);
    localparam logic [REP_W-1:0]     REP_HALT   = REP_W'(HALT_REPEAT - 2);
    localparam logic [REP_W-1:0]     REP_MAX    = REP_W'(HALT_REPEAT - 1);
    localparam logic [CNT_WIDTH-1:0] LAST_CYCLE = CNT_WIDTH'(MAX_CYCLES - 1);

    state_t                st, st_n;
    logic [HOLD_W-1:0]     hold_cnt, hold_cnt_n;
    logic [REP_W-1:0]      rep_cnt, rep_cnt_n;
    logic [PC_WIDTH-1:0]   last_pc, last_pc_n;
    logic                  last_pc_ok, last_pc_ok_n;
    logic [CNT_WIDTH-1:0]  cycle_n, instr_n;
    logic                  cpu_reset_n, halted_n, timeout_n, done_n;
    logic                  pc_match, halt_fire;
`ifdef RUN_CTRL_SIG_EN
    logic [31:0]           signature_n;
    logic [PC_WIDTH+31:0]  pc_ext;
    assign pc_ext = {32'b0, pc};
`endif

    assign state    = st;
    assign pc_match = last_pc_ok && (pc == last_pc);

    always_comb begin
        st_n         = st;
        hold_cnt_n   = hold_cnt;
        rep_cnt_n    = rep_cnt;
        last_pc_n    = last_pc;
        last_pc_ok_n = last_pc_ok;
        cycle_n      = cycle_count;
        instr_n      = instr_count;
        cpu_reset_n  = cpu_reset;
        halted_n     = halted;
        timeout_n    = timeout;
        done_n       = done;
        halt_fire    = 1'b0;
`ifdef RUN_CTRL_SIG_EN
        signature_n  = signature;
`endif
        case (st)
            ST_RESET: begin
                st_n       = ST_HOLD;
                hold_cnt_n = HOLD_W'(1);
            end
            ST_HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    st_n        = ST_RUN;
                    cpu_reset_n = 1'b0;
                end else begin
                    hold_cnt_n = hold_cnt + HOLD_W'(1);
                end
            end
            ST_RUN: begin
                cycle_n = cycle_count + CNT_WIDTH'(1);
                if (pc_valid) begin
                    instr_n = instr_count + CNT_WIDTH'(1);
`ifdef RUN_CTRL_SIG_EN
                    signature_n = {signature[30:0], signature[31]} ^ pc_ext[31:0];
`endif
                    if (pc_match) begin
                        // rep_cnt counts repeats after the first occurrence, so HALT_REPEAT-2 means this is the last one
                        halt_fire = (rep_cnt == REP_HALT);
                        if (rep_cnt != REP_MAX)
                            rep_cnt_n = rep_cnt + REP_W'(1);
                    end else begin
                        rep_cnt_n    = '0;
                        last_pc_n    = pc;
                        last_pc_ok_n = 1'b1;
                    end
                end
                if (halt_fire) begin
                    halted_n = 1'b1;
                    done_n   = 1'b1;
                    st_n     = ST_DONE;
                end else if (cycle_count == LAST_CYCLE) begin
                    timeout_n = 1'b1;
                    done_n    = 1'b1;
                    st_n      = ST_DONE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st          <= ST_RESET;
            hold_cnt    <= '0;
            rep_cnt     <= '0;
            last_pc     <= '0;
            last_pc_ok  <= 1'b0;
            cycle_count <= '0;
            instr_count <= '0;
            cpu_reset   <= 1'b1;
            halted      <= 1'b0;
            timeout     <= 1'b0;
            done        <= 1'b0;
`ifdef RUN_CTRL_SIG_EN
            signature   <= '0;
`endif
        end else begin
            st          <= st_n;
            hold_cnt    <= hold_cnt_n;
            rep_cnt     <= rep_cnt_n;
            last_pc     <= last_pc_n;
            last_pc_ok  <= last_pc_ok_n;
            cycle_count <= cycle_n;
            instr_count <= instr_n;
            cpu_reset   <= cpu_reset_n;
            halted      <= halted_n;
            timeout     <= timeout_n;
            done        <= done_n;
`ifdef RUN_CTRL_SIG_EN
            signature   <= signature_n;
`endif
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: two configurations share one stimulus stream and are checked against a run-level model.
module tb_cpu_run_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc = '0;
    logic        pc_valid = 1'b0;

    logic        a_cpu_reset, a_halted, a_timeout, a_done;
    logic [1:0]  a_state;
    logic [31:0] a_cycle, a_instr;
    logic        b_cpu_reset, b_halted, b_timeout, b_done;
    logic [1:0]  b_state;
    logic [31:0] b_cycle, b_instr;
`ifdef RUN_CTRL_SIG_EN
    logic [31:0] a_sig, b_sig;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_run_ctrl #(.PC_WIDTH(32), .CNT_WIDTH(32), .RESET_CYCLES(4), .MAX_CYCLES(100), .HALT_REPEAT(8)) dut_a (
        .clk(clk), .reset(reset), .pc(pc), .pc_valid(pc_valid),
        .cpu_reset(a_cpu_reset), .state(a_state), .cycle_count(a_cycle), .instr_count(a_instr),
        .halted(a_halted), .timeout(a_timeout), .done(a_done)
`ifdef RUN_CTRL_SIG_EN
        , .signature(a_sig)
`endif
    );

    cpu_run_ctrl #(.PC_WIDTH(32), .CNT_WIDTH(32), .RESET_CYCLES(2), .MAX_CYCLES(10), .HALT_REPEAT(10)) dut_b (
        .clk(clk), .reset(reset), .pc(pc), .pc_valid(pc_valid),
        .cpu_reset(b_cpu_reset), .state(b_state), .cycle_count(b_cycle), .instr_count(b_instr),
        .halted(b_halted), .timeout(b_timeout), .done(b_done)
`ifdef RUN_CTRL_SIG_EN
        , .signature(b_sig)
`endif
    );

    function automatic int unsigned rc_of(input int k); return (k == 0) ? 4 : 2;   endfunction
    function automatic int unsigned mx_of(input int k); return (k == 0) ? 100 : 10; endfunction
    function automatic int unsigned hr_of(input int k); return (k == 0) ? 8 : 10;   endfunction

    // Model: edges since release, run totals, and the length of the trailing run of identical valid PCs.
    int unsigned m_rel[2], m_cyc[2], m_ins[2], m_streak[2];
    logic [31:0] m_lp[2], m_sig[2];
    bit          m_halt[2], m_to[2];

    always @(posedge clk or posedge reset) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_rel[k] = 0; m_cyc[k] = 0; m_ins[k] = 0; m_streak[k] = 0;
                m_lp[k] = '0; m_sig[k] = '0; m_halt[k] = 0; m_to[k] = 0;
            end else begin
                if (m_rel[k] >= rc_of(k) + 1 && !(m_halt[k] || m_to[k])) begin
                    m_cyc[k]++;
                    if (pc_valid) begin
                        m_ins[k]++;
                        m_sig[k] = {m_sig[k][30:0], m_sig[k][31]} ^ pc;
                        if (m_streak[k] > 0 && pc == m_lp[k]) m_streak[k]++;
                        else begin m_streak[k] = 1; m_lp[k] = pc; end
                    end
                    if (pc_valid && m_streak[k] >= hr_of(k)) m_halt[k] = 1;
                    else if (m_cyc[k] == mx_of(k))         m_to[k] = 1;
                end
                if (m_rel[k] < 1000) m_rel[k]++;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cmp(input string n, input int k, input logic cr, input logic [1:0] st,
                       input logic [31:0] cc, input logic [31:0] ic, input logic h, input logic t, input logic d);
        bit          md;
        logic [1:0]  es;
        md = m_halt[k] || m_to[k];
        if (reset || m_rel[k] == 0)     es = 2'd0;
        else if (m_rel[k] <= rc_of(k))  es = 2'd1;
        else                            es = md ? 2'd3 : 2'd2;
        chk({n, ".state"},     32'(st), 32'(es));
        chk({n, ".cpu_reset"}, 32'(cr), 32'(reset || m_rel[k] <= rc_of(k)));
        chk({n, ".cycles"},    cc, m_cyc[k]);
        chk({n, ".instrs"},    ic, m_ins[k]);
        chk({n, ".halted"},    32'(h), 32'(m_halt[k]));
        chk({n, ".timeout"},   32'(t), 32'(m_to[k]));
        chk({n, ".done"},      32'(d), 32'(md));
    endtask

    always @(posedge clk) begin
        #1;
        cmp("a", 0, a_cpu_reset, a_state, a_cycle, a_instr, a_halted, a_timeout, a_done);
        cmp("b", 1, b_cpu_reset, b_state, b_cycle, b_instr, b_halted, b_timeout, b_done);
`ifdef RUN_CTRL_SIG_EN
        chk("a.signature", a_sig, m_sig[0]);
        chk("b.signature", b_sig, m_sig[1]);
`endif
    end

    task automatic drive(input logic [31:0] p, input logic v);
        @(negedge clk);
        pc = p;
        pc_valid = v;
    endtask

    // Leaves the bench just after the edge on which dut_a enters RUN.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst.state", 32'(a_state), 32'd0);
        chk("rst.cpu_reset", 32'(a_cpu_reset), 32'd1);
        reset = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            @(posedge clk);
            #1;
            chk("rel.state", 32'(a_state), (e <= 4) ? 32'd1 : 32'd2);
            chk("rel.cpu_reset", 32'(a_cpu_reset), (e <= 4) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 reset = 1'b1;

        // halt after three distinct PCs and eight copies of 0x300C
        do_reset();
        drive(32'h3000, 1); drive(32'h3004, 1); drive(32'h3008, 1);
        repeat (8) drive(32'h300C, 1);
        drive(32'h0, 0);
        chk("halt.halted", 32'(a_halted), 32'd1);
        chk("halt.done", 32'(a_done), 32'd1);
        chk("halt.instrs", a_instr, 32'd11);
        chk("halt.timeout", 32'(a_timeout), 32'd0);
        chk("halt.cycles", a_cycle, 32'd11);

        // bubbles between repeats do not break the run but do count as cycles
        do_reset();
        drive(32'h3000, 1); drive(32'h3004, 1); drive(32'h3008, 1);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) chk("bubble.early", 32'(a_halted), 32'd0);
            drive(32'h300C, 1);
            if (i < 7) drive(32'h0, 0);
        end
        drive(32'h0, 0);
        chk("bubble.halted", 32'(a_halted), 32'd1);
        chk("bubble.instrs", a_instr, 32'd11);
        chk("bubble.cycles", a_cycle, 32'd18);

        // budget expiry with a steadily advancing PC
        do_reset();
        for (int i = 0; i < 105; i++) drive(32'h100 + 32'(4 * i), 1);
        drive(32'h0, 0);
        chk("tmo.timeout", 32'(a_timeout), 32'd1);
        chk("tmo.cycles", a_cycle, 32'd100);
        chk("tmo.instrs", a_instr, 32'd100);
        chk("tmo.halted", 32'(a_halted), 32'd0);

`ifdef RUN_CTRL_SIG_EN
        do_reset();
        drive(32'h1, 1);
        drive(32'h2, 1);
        chk("sig.first", a_sig, 32'h1);
        drive(32'h0, 0);
        chk("sig.second", a_sig, 32'h0);
`endif

        // constant PC from dut_b's first RUN cycle: halt and budget coincide
        pc = 32'h40;
        pc_valid = 1'b1;
        do_reset();
        repeat (10) @(negedge clk);
        chk("tie.halted", 32'(b_halted), 32'd1);
        chk("tie.timeout", 32'(b_timeout), 32'd0);
        chk("tie.cycles", b_cycle, 32'd10);
        chk("tie.instrs", b_instr, 32'd10);
        chk("tie.state", 32'(b_state), 32'd3);
        chk("tie.a_instrs", a_instr, 32'd8);

        // asynchronous reset from DONE, mid-cycle
        #2 reset = 1'b1;
        #1;
        chk("arst.state", 32'(b_state), 32'd0);
        chk("arst.cpu_reset", 32'(b_cpu_reset), 32'd1);
        chk("arst.cycles", b_cycle, 32'd0);
        chk("arst.instrs", b_instr, 32'd0);
        chk("arst.halted", 32'(b_halted), 32'd0);
        chk("arst.done", 32'(b_done), 32'd0);
        chk("arst.a_done", 32'(a_done), 32'd0);
        pc_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
